// File: rtl/accumulator_unit.sv
// Accumulator stage of the basic-computer datapath: AC and E registers,
// one register-reference/ALU micro-operation per accepted command.

// BITS-wide ripple-carry adder shared by ADD and INC.
module ripple_carry_adder #(
  parameter int unsigned BITS = 16
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            c_in,
  output logic [BITS-1:0] sum,
  output logic            c_out
);

  // Carry ripples LSB to MSB through one full adder per bit.
  always_comb begin
    logic carry;
    carry = c_in;
    sum   = '0;
    for (int i = 0; i < int'(BITS); i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    c_out = carry;
  end

endmodule

module accumulator_unit #(
  parameter int unsigned BITS      = 16,
  parameter int unsigned INPR_BITS = 8
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic [3:0]           op_in,
  input  logic                 op_valid_in,
  input  logic [BITS-1:0]      dr_in,
  input  logic [INPR_BITS-1:0] inpr_in,
  output logic [BITS-1:0]      ac_out,
  output logic                 e_out,
  output logic                 ac_zero_out,
  output logic                 ac_sign_out,
  output logic                 e_zero_out,
  output logic                 done_out
);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_LDA = 4'd3;
  localparam logic [3:0] OP_CLA = 4'd4;
  localparam logic [3:0] OP_CLE = 4'd5;
  localparam logic [3:0] OP_CMA = 4'd6;
  localparam logic [3:0] OP_CME = 4'd7;
  localparam logic [3:0] OP_CIR = 4'd8;
  localparam logic [3:0] OP_CIL = 4'd9;
  localparam logic [3:0] OP_INC = 4'd10;
  localparam logic [3:0] OP_INP = 4'd11;

  // Low INPR_BITS of AC are replaced by INP; the rest are kept.
  localparam logic [BITS-1:0] INPR_MASK = BITS'({INPR_BITS{1'b1}});

  logic [BITS-1:0] ac_next;
  logic            e_next;
  logic [BITS-1:0] add_b;
  logic            add_cin;
  logic [BITS-1:0] add_sum;
  logic            add_cout;

  // Adder operands: DR for ADD, zero plus carry-in for INC.
  always_comb begin
    add_b   = (op_in == OP_ADD) ? dr_in : '0;
    add_cin = (op_in == OP_INC);
  end

  ripple_carry_adder #(
    .BITS (BITS)
  ) u_adder (
    .a     (ac_out),
    .b     (add_b),
    .c_in  (add_cin),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  // Next AC/E; the opcode is only looked at when a command is offered.
  always_comb begin
    ac_next = ac_out;
    e_next  = e_out;
    if (op_valid_in) begin
      case (op_in)
        OP_AND: ac_next = ac_out & dr_in;
        OP_ADD: begin
          ac_next = add_sum;
          e_next  = add_cout;
        end
        OP_LDA: ac_next = dr_in;
        OP_CLA: ac_next = '0;
        OP_CLE: e_next  = 1'b0;
        OP_CMA: ac_next = ~ac_out;
        OP_CME: e_next  = ~e_out;
        OP_CIR: begin
          ac_next = {e_out, ac_out[BITS-1:1]};
          e_next  = ac_out[0];
        end
        OP_CIL: begin
          ac_next = {ac_out[BITS-2:0], e_out};
          e_next  = ac_out[BITS-1];
        end
        OP_INC: ac_next = add_sum;
        OP_INP: ac_next = (ac_out & ~INPR_MASK) | BITS'(inpr_in);
        default: begin
          ac_next = ac_out;
          e_next  = e_out;
        end
      endcase
    end
  end

  // AC, E and the completion pulse.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      ac_out   <= '0;
      e_out    <= 1'b0;
      done_out <= 1'b0;
    end else begin
      ac_out   <= ac_next;
      e_out    <= e_next;
      done_out <= op_valid_in;
    end
  end

  // Status flags read by the control unit for skip decisions.
  always_comb begin
    ac_zero_out = (ac_out == '0);
    ac_sign_out = ac_out[BITS-1];
    e_zero_out  = ~e_out;
  end

endmodule

// File: tb/tb_accumulator_unit.sv
// Self-checking bench for accumulator_unit: directed scenarios plus random
// command streams compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_accumulator_unit;

  localparam int unsigned BITS      = 16;
  localparam int unsigned INPR_BITS = 8;
  localparam int unsigned MASK      = (1 << BITS) - 1;
  localparam int unsigned IMASK     = (1 << INPR_BITS) - 1;

  logic                 clk_in = 1'b0;
  logic                 reset_in;
  logic [3:0]           op_in;
  logic                 op_valid_in;
  logic [BITS-1:0]      dr_in;
  logic [INPR_BITS-1:0] inpr_in;
  logic [BITS-1:0]      ac_out;
  logic                 e_out;
  logic                 ac_zero_out;
  logic                 ac_sign_out;
  logic                 e_zero_out;
  logic                 done_out;

  int total = 0;
  int bad   = 0;

  // Reference state
  int unsigned m_ac;
  int unsigned m_e;

  accumulator_unit #(
    .BITS      (BITS),
    .INPR_BITS (INPR_BITS)
  ) dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .op_in       (op_in),
    .op_valid_in (op_valid_in),
    .dr_in       (dr_in),
    .inpr_in     (inpr_in),
    .ac_out      (ac_out),
    .e_out       (e_out),
    .ac_zero_out (ac_zero_out),
    .ac_sign_out (ac_sign_out),
    .e_zero_out  (e_zero_out),
    .done_out    (done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model.
  task automatic check_state(input string tag, input bit exp_done);
    check({tag, ".ac"},   32'(ac_out), m_ac);
    check({tag, ".e"},    32'(e_out), m_e);
    check({tag, ".done"}, 32'(done_out), 32'(exp_done));
    check({tag, ".zero"}, 32'(ac_zero_out), 32'(m_ac == 0));
    check({tag, ".sign"}, 32'(ac_sign_out), (m_ac >> (BITS - 1)) & 1);
    check({tag, ".ez"},   32'(e_zero_out), 32'(m_e == 0));
  endtask

  // Effect of one operation expressed on whole-word integers.
  task automatic model_op(input int unsigned op, input int unsigned dr, input int unsigned inpr);
    int unsigned s;
    int unsigned old_ac;
    int unsigned old_e;
    old_ac = m_ac;
    old_e  = m_e;
    case (op)
      1:  m_ac = old_ac & dr;
      2:  begin
            s    = old_ac + dr;
            m_ac = s & MASK;
            m_e  = (s >> BITS) & 1;
          end
      3:  m_ac = dr;
      4:  m_ac = 0;
      5:  m_e  = 0;
      6:  m_ac = (~old_ac) & MASK;
      7:  m_e  = old_e ^ 1;
      8:  begin
            m_ac = (old_e << (BITS - 1)) | (old_ac >> 1);
            m_e  = old_ac & 1;
          end
      9:  begin
            m_ac = ((old_ac << 1) | old_e) & MASK;
            m_e  = (old_ac >> (BITS - 1)) & 1;
          end
      10: m_ac = (old_ac + 1) & MASK;
      11: m_ac = (old_ac & ~IMASK & MASK) | (inpr & IMASK);
      default: ;
    endcase
  endtask

  // Issue one command at the current falling edge; check after the accepting edge.
  task automatic do_op(input int unsigned op, input int unsigned dr, input int unsigned inpr, input string tag);
    op_in       = 4'(op);
    dr_in       = BITS'(dr);
    inpr_in     = INPR_BITS'(inpr);
    op_valid_in = 1'b1;
    @(posedge clk_in);
    model_op(op, dr, inpr);
    @(negedge clk_in);
    check_state(tag, 1'b1);
  endtask

  // One idle cycle with garbage on the command inputs.
  task automatic idle(input string tag);
    op_valid_in = 1'b0;
    op_in       = 4'($urandom_range(0, 15));
    dr_in       = BITS'($urandom);
    inpr_in     = INPR_BITS'($urandom);
    @(posedge clk_in);
    @(negedge clk_in);
    check_state(tag, 1'b0);
  endtask

  initial begin
    reset_in    = 1'b1;
    op_valid_in = 1'b0;
    op_in       = '0;
    dr_in       = '0;
    inpr_in     = '0;
    m_ac        = 0;
    m_e         = 0;
    repeat (3) @(negedge clk_in);
    check_state("reset", 1'b0);
    reset_in = 1'b0;

    // Reset mid-stream while a command is being offered
    do_op(3, 16'h1234, 0, "rst_lda");
    do_op(7, 0, 0, "rst_cme");
    check("rst_pre_ac", 32'(ac_out), 32'h1234);
    do_op(3, 16'hbeef, 0, "rst_pend");
    op_in = 4'd3;
    dr_in = 16'h5555;
    #2 reset_in = 1'b1;
    #1;
    m_ac = 0;
    m_e  = 0;
    check_state("rst_async", 1'b0);
    @(negedge clk_in);
    op_valid_in = 1'b0;
    @(negedge clk_in);
    check_state("rst_hold", 1'b0);
    reset_in = 1'b0;
    do_op(3, 16'h0042, 0, "rst_after");
    check("rst_after_k", 32'(ac_out), 32'h0042);

    // ADD chain
    do_op(3, 16'hae43, 0, "add_lda");
    do_op(2, 16'hae43, 0, "add1");
    check("add1_k", {15'd0, e_out, ac_out}, {15'd0, 1'b1, 16'h5c86});
    do_op(5, 0, 0, "add_cle");
    do_op(2, 16'h0000, 0, "add2");
    check("add2_k", {15'd0, e_out, ac_out}, {15'd0, 1'b0, 16'h5c86});

    // INC wrap leaves E alone
    do_op(3, 16'hffff, 0, "inc_lda");
    do_op(7, 0, 0, "inc_cme");
    do_op(10, 0, 0, "inc_wrap");
    check("inc_wrap_k", {14'd0, ac_zero_out, e_out, ac_out}, {14'd0, 1'b1, 1'b1, 16'h0000});
    do_op(10, 0, 0, "inc_again");
    check("inc_again_k", {15'd0, ac_zero_out, ac_out}, {15'd0, 1'b0, 16'h0001});

    // Rotates through E
    do_op(3, 16'h8001, 0, "rot_lda");
    do_op(5, 0, 0, "rot_cle");
    do_op(8, 0, 0, "rot_cir");
    check("rot_cir_k", {15'd0, e_out, ac_out}, {15'd0, 1'b1, 16'h4000});
    do_op(9, 0, 0, "rot_cil1");
    check("rot_cil1_k", {15'd0, e_out, ac_out}, {15'd0, 1'b0, 16'h8001});
    do_op(9, 0, 0, "rot_cil2");
    check("rot_cil2_k", {14'd0, ac_sign_out, e_out, ac_out}, {14'd0, 1'b0, 1'b1, 16'h0002});

    // Logic ops, INP, reserved opcode
    do_op(3, 16'hf0f0, 0, "log_lda");
    do_op(1, 16'h3c3c, 0, "log_and");
    check("log_and_k", 32'(ac_out), 32'h3030);
    do_op(6, 0, 0, "log_cma");
    check("log_cma_k", {15'd0, ac_sign_out, ac_out}, {15'd0, 1'b1, 16'hcfcf});
    do_op(11, 16'hffff, 8'h5a, "log_inp");
    check("log_inp_k", 32'(ac_out), 32'hcf5a);
    do_op(13, 16'h1111, 8'h22, "log_rsv");
    check("log_rsv_k", {15'd0, done_out, ac_out}, {15'd0, 1'b1, 16'hcf5a});
    do_op(4, 0, 0, "log_cla");
    do_op(0, 16'hffff, 0, "log_nop");

    // Idle hold
    do_op(3, 16'h9c3e, 0, "idle_lda");
    do_op(7, 0, 0, "idle_cme");
    for (int i = 0; i < 5; i++) idle("idle");

    // Random command stream, mostly back-to-back with occasional gaps
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 8)
        do_op($urandom_range(0, 15), $urandom & MASK, $urandom & IMASK, "rand");
      else
        idle("rand_idle");
    end

    op_valid_in = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accumulator_unit.md
Name: accumulator_unit

Overview:
- Registered accumulator stage of the basic-computer datapath.
- Holds AC (BITS wide) and the E (extend/carry) flip-flop.
- Executes one register-reference or ALU micro-operation per accepted command.
- Contains one RippleCarryAdder instance (BITS wide) for ADD and INC, and consumes its sum and carry-out into AC/E.
- Sits between the DR/INPR buses and the control unit, which reads its flags for skip decisions.

Parameters:
- BITS, 16, width of AC, DR and the adder.
- INPR_BITS, 8, width of the input register loaded by INP (must be <= BITS).

Ports:
- clk_in  input  1  clock, rising-edge active.
- reset_in  input  1  asynchronous, active-high reset.
- op_in  input  4  micro-operation code, sampled when op_valid_in=1.
- op_valid_in  input  1  command strobe; one operation per cycle it is high.
- dr_in  input  BITS  data register operand.
- inpr_in  input  INPR_BITS  input register operand.
- ac_out  output  BITS  accumulator register.
- e_out  output  1  E flip-flop.
- ac_zero_out  output  1  combinational, 1 when ac_out==0.
- ac_sign_out  output  1  combinational, ac_out[BITS-1].
- e_zero_out  output  1  combinational, ~e_out.
- done_out  output  1  registered one-cycle completion pulse.

Behaviour:
- Reset: asynchronous, active-high. While reset_in=1: ac_out=0, e_out=0, done_out=0 immediately, regardless of clock. Reset asserted mid-operation discards that operation and produces no done pulse. First operation is accepted on the first rising edge after reset_in falls.
- Opcode encoding (applied at the rising edge where op_valid_in=1):
  - 0 NOP: no change.
  - 1 AND: AC<=AC&DR.
  - 2 ADD: {E,AC}<=AC+DR, carry-in 0, E=adder carry-out.
  - 3 LDA: AC<=DR.
  - 4 CLA: AC<=0.
  - 5 CLE: E<=0.
  - 6 CMA: AC<=~AC.
  - 7 CME: E<=~E.
  - 8 CIR: {AC,E}<={E,AC}; new AC[BITS-1]=old E, new E=old AC[0].
  - 9 CIL: {E,AC}<={AC,E}; new E=old AC[BITS-1], new AC[0]=old E.
  - 10 INC: AC<=AC+1 via adder (b=0, c_in=1). E unchanged; overflow 0xFFFF->0x0000 leaves E as-is.
  - 11 INP: AC[INPR_BITS-1:0]<=INPR; upper bits unchanged.
  - 12-15: reserved, treated as NOP.
- Registers not named by the operation hold their value.
- Latency: results are visible on ac_out/e_out after the accepting edge. done_out=1 for exactly the following cycle, for every accepted opcode including NOP/reserved.
- Back-to-back: op_valid_in held high issues one operation per cycle. Each operation uses the AC/E produced by the previous one; no stalls, no busy.
- op_valid_in=0: registers hold, done_out=0 next cycle.
- Arithmetic: all modulo 2^BITS. The adder carry-out feeds E only for ADD.
- Flags: combinational from current registers, with no extra latency. They update in the same cycle as ac_out.
- Op/operand inputs are sampled only at the edge. X on op_in while op_valid_in=0 must not affect state.

Test Plan:
- Reset mid-stream: load AC=0x1234, E=1, assert reset_in between edges -> ac_out=0, e_out=0, done_out=0 asynchronously. Next op after release executes normally.
- ADD chain: LDA dr=0xae43, then ADD dr=0xae43 -> AC=0x5c86, E=1. Then CLE, ADD dr=0x0000 -> AC=0x5c86, E=0. done pulses each cycle.
- INC wrap: LDA 0xFFFF, CME (E=1), INC -> AC=0x0000, E=1 unchanged, ac_zero_out=1. INC again -> AC=0x0001, ac_zero_out=0.
- Rotates: LDA 0x8001, CLE, CIR -> AC=0x4000, E=1. CIL -> AC=0x8001, E=0. CIL -> AC=0x0002, E=1, ac_sign_out=0.
- Logic/INP: LDA 0xF0F0, AND dr=0x3C3C -> 0x3030. CMA -> 0xCFCF, ac_sign_out=1. INP inpr=0x5A -> 0xCF5A. Opcode 13 -> no change, done_out=1.
- Idle hold: op_valid_in=0 for 5 cycles with random op_in/dr_in -> AC/E stable, done_out=0.
